rf_bank_arbiter: RTL

Parametrised register-file bank arbiter for the operand-collector stage; successor to the fixed 4-bank, 8-row RF controller. It accepts one- or two-operand read requests from the dispatch/parallel-control stage, splits each operand into the queue of its target bank, and issues at most one access per bank per cycle. Write-back from the CDB takes priority over reads. Collectors receive per-bank valid/ocid/operand tags aligned with bank read data.

---
 rtl/rf_arb_pkg.sv | 32 +++
 rtl/rf_bank_arbiter_if.sv | 40 ++++
 rtl/rf_req_fifo.sv | 53 +++++
 rtl/rf_bank_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared sizing, request entry type and address helpers
// for the register-file bank arbiter.
package rf_arb_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int NUM_OC     = 4;
    localparam int ROW_W      = 3;
    localparam int FIFO_DEPTH = 4;

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int OCID_W = $clog2(NUM_OC);
    localparam int ADDR_W = ROW_W + BANK_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef logic [ADDR_W-1:0] rf_addr_t;

    typedef struct packed {
        logic [OCID_W-1:0] ocid;
        logic [ROW_W-1:0]  row;
        logic              opsel;
    } rf_req_t;

    function automatic logic [BANK_W-1:0] addr_bank(rf_addr_t a);
        return a[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(rf_addr_t a);
        return a[ADDR_W-1:BANK_W];
    endfunction

endpackage

// File: rtl/rf_bank_arbiter_if.sv
// Dispatch, write-back and per-bank signals of the
// register-file bank arbiter; master drives requests.
interface rf_bank_arbiter_if;
    import rf_arb_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_two_op;
    logic [OCID_W-1:0]           req_ocid;
    rf_addr_t                    req_reg_a;
    rf_addr_t                    req_reg_b;
    logic                        wb_valid;
    rf_addr_t                    wb_addr;
    logic [NUM_BANKS-1:0]        bank_wr_en;
    logic [NUM_BANKS-1:0]        bank_rd_en;
    logic [NUM_BANKS*ROW_W-1:0]  bank_row;
    logic [NUM_BANKS-1:0]        bk_vld;
    logic [NUM_BANKS*OCID_W-1:0] bk_ocid;
    logic [NUM_BANKS-1:0]        bk_opsel;
    logic [NUM_BANKS-1:0]        bk_bz;

    modport master (
        output req_valid, req_two_op, req_ocid,
        output req_reg_a, req_reg_b,
        output wb_valid, wb_addr,
        input  req_ready,
        input  bank_wr_en, bank_rd_en, bank_row,
        input  bk_vld, bk_ocid, bk_opsel, bk_bz
    );

    modport slave (
        input  req_valid, req_two_op, req_ocid,
        input  req_reg_a, req_reg_b,
        input  wb_valid, wb_addr,
        output req_ready,
        output bank_wr_en, bank_rd_en, bank_row,
        output bk_vld, bk_ocid, bk_opsel, bk_bz
    );

endinterface

// File: rtl/rf_req_fifo.sv
// Per-bank request queue: up to two pushes (a before b)
// and one pop per cycle, registered occupancy count.
module rf_req_fifo
    import rf_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a,
    input  rf_req_t          data_a,
    input  logic             push_b,
    input  rf_req_t          data_b,
    input  logic             pop,
    output rf_req_t          head,
    output logic [CNT_W-1:0] count
);

    rf_req_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    rf_req_t          first;
    logic [1:0]       n_push;

    // Lone b push lands in the first free slot like an a push
    always_comb begin
        first  = push_a ? data_a : data_b;
        n_push = {1'b0, push_a} + {1'b0, push_b};
    end

    assign head = mem[rd_ptr];

    // Storage write; a takes the lower slot when both push
    always_ff @(posedge clk) begin
        if (push_a || push_b)
            mem[wr_ptr] <= first;
        if (push_a && push_b)
            mem[wr_ptr + PTR_W'(1)] <= data_b;
    end

    // Pointers wrap naturally; count tracks pushes minus pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/rf_bank_arbiter.sv
// Operand-collector RF bank arbiter: per-bank queues, CDB write
// priority, tagged reads. Optional counter: RF_ARB_PERF_EN.
module rf_bank_arbiter
    import rf_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef RF_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [15:0]       perf_conflict_cnt,
`endif
    rf_bank_arbiter_if.slave  bus
);

    logic [BANK_W-1:0]    bank_a;
    logic [BANK_W-1:0]    bank_b;
    logic [BANK_W-1:0]    wb_bank;
    logic [ROW_W-1:0]     wb_row;
    rf_req_t              ent_a;
    rf_req_t              ent_b;
    logic                 ready;
    logic                 fire;
    logic [NUM_BANKS-1:0] fits;
    logic [NUM_BANKS-1:0] wb_hit;
    logic [NUM_BANKS-1:0] busy;

    assign bank_a  = addr_bank(bus.req_reg_a);
    assign bank_b  = addr_bank(bus.req_reg_b);
    assign wb_bank = addr_bank(bus.wb_addr);
    assign wb_row  = addr_row(bus.wb_addr);

    assign ent_a = '{ocid: bus.req_ocid,
                     row: addr_row(bus.req_reg_a),
                     opsel: 1'b0};
    assign ent_b = '{ocid: bus.req_ocid,
                     row: addr_row(bus.req_reg_b),
                     opsel: 1'b1};

    // Ready only looks at registered counts, never req_valid
    assign ready         = &fits;
    assign bus.req_ready = ready;
    assign fire          = bus.req_valid && ready;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [CNT_W-1:0]  cnt;
        rf_req_t           head;
        logic [1:0]        need;
        logic              hit_a;
        logic              hit_b;
        logic              pop;
        logic              vld_q;
        logic [OCID_W-1:0] ocid_q;
        logic              opsel_q;

        assign hit_a = bank_a == BANK_W'(b);
        assign hit_b = bus.req_two_op && bank_b == BANK_W'(b);
        assign need  = {1'b0, hit_a} + {1'b0, hit_b};

        assign fits[b] = CNT_W'(need) + cnt
                         <= CNT_W'(FIFO_DEPTH);

        assign wb_hit[b] = bus.wb_valid && wb_bank == BANK_W'(b);
        assign busy[b]   = cnt != '0;
        assign pop       = !wb_hit[b] && busy[b];

        rf_req_fifo u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_a (fire && hit_a),
            .data_a (ent_a),
            .push_b (fire && hit_b),
            .data_b (ent_b),
            .pop    (pop),
            .head   (head),
            .count  (cnt)
        );

        assign bus.bank_wr_en[b] = wb_hit[b];
        assign bus.bank_rd_en[b] = pop;
        assign bus.bk_bz[b]      = busy[b];

        assign bus.bank_row[b*ROW_W +: ROW_W] =
            wb_hit[b] ? wb_row :
            pop       ? head.row : '0;

        // Tag follows the read by one cycle, like the SRAM data
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q   <= 1'b0;
                ocid_q  <= '0;
                opsel_q <= 1'b0;
            end else begin
                vld_q   <= pop;
                ocid_q  <= pop ? head.ocid : '0;
                opsel_q <= pop && head.opsel;
            end
        end

        assign bus.bk_vld[b]                    = vld_q;
        assign bus.bk_ocid[b*OCID_W +: OCID_W]  = ocid_q;
        assign bus.bk_opsel[b]                  = opsel_q;
    end

`ifdef RF_ARB_PERF_EN
    logic [1:0]  perf_inc;
    logic [16:0] perf_sum;

    assign perf_inc = {1'b0, |(wb_hit & busy)}
                    + {1'b0, bus.req_valid && !ready};
    assign perf_sum = {1'b0, perf_conflict_cnt} + 17'(perf_inc);

    // Blocked-read and rejected-request cycles, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_conflict_cnt <= '0;
        else if (perf_clr)
            perf_conflict_cnt <= '0;
        else
            perf_conflict_cnt <= perf_sum[16] ? 16'hFFFF
                                              : perf_sum[15:0];
    end
`endif

endmodule
